jk_excite_seq: RTL and testbench
================================

// Module: jk_excite_seq
// PURPOSE
//  Upstream driver for a bank of WIDTH JK flip-flops. Accepts target bit-vectors over a
//  valid/ready stream, buffers them, computes per-bit J/K excitation and drives one update per entry.
//  Tracks a model of the flop state, which equals the flop reset value because both share rst.
//  Optionally checks the flop outputs fed back on q_fb.
// PARAMETERS
//  WIDTH  4  number of JK flops driven (bits per target)
//  DEPTH  4  target FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      target entry offered
//  in_ready    out  1      FIFO can accept; = !full
//  in_data     in   WIDTH  target flop state
//  in_tog      in   1      1: flip differing bits with JK=11; 0: use 10/01 set/reset
//  j           out  WIDTH  J excitation to flop bank, registered
//  k           out  WIDTH  K excitation to flop bank, registered
//  q_fb        in   WIDTH  flop bank outputs (feedback)
//  busy        out  1      FSM not IDLE or FIFO non-empty
//  done        out  1      one-cycle pulse per completed entry
//  err         out  1      sticky feedback mismatch (LOOPBACK_CHECK_EN)
//  err_bits    out  WIDTH  XOR of model vs q_fb at first mismatch
// BEHAVIOUR
//  Reset: j=k=0, model=0, FIFO empty, state=IDLE, done=0, err=0, err_bits=0; in_ready=1 the cycle after.
//    Reset mid-operation discards the entry in flight and all queued entries.
//  FIFO: stores {in_tog,in_data}. Push when in_valid&&in_ready. No write-through.
//    When full, in_ready=0 and in_data is ignored. Push and pop in the same cycle are legal; count is unchanged.
//  Excitation, per bit i, from model m, target t, tog bit: t==m -> 00;
//    t!=m && tog -> 11; t!=m && !tog -> t ? 10 : 01.
//  FSM states IDLE, APPLY, SETTLE:
//    IDLE   : FIFO non-empty -> pop, tgt<=entry, j/k<=excite(model,entry), ->APPLY; else stay.
//    APPLY  : j<=0,k<=0, ->SETTLE. The flop bank captures J/K on this same edge.
//    SETTLE : q_fb valid. model<=tgt, done<=1.
//             FIFO non-empty -> pop, excite against tgt (the new model), ->APPLY; else ->IDLE.
//  Latency: entry pushed at edge N; j/k visible after edge N+1; done high after edge N+3.
//    Back-to-back throughput is one entry per 2 cycles.
//  An entry equal to model still takes a full APPLY/SETTLE pass with j=k=0 and raises done.
//  j/k are non-zero only in APPLY; they are 00 in every other cycle.
// CONFIGURATION
//  `LOOPBACK_CHECK_EN defined: in SETTLE compare q_fb against tgt.
//    On mismatch while err==0: err<=1, err_bits<=q_fb^tgt. Both hold until rst.
//  Not defined: err=0 and err_bits=0 constantly, q_fb ignored (port retained); all else identical.
// STRUCTURE
//  Package jk_pkg: state localparams ST_IDLE/ST_APPLY/ST_SETTLE (2-bit);
//    JK codes JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
//  Sub-module jk_tgt_fifo: synchronous FIFO, width WIDTH+1, depth DEPTH.
//    Wrap-around pointers with an extra MSB for full/empty.
//  Top level holds the FSM, model/tgt registers, excitation function and checker.
// TESTING (bench instantiates this block plus a JK flop bank on the same clk/rst, q -> q_fb)
//  1. rst=1 for 2 cycles -> j=k=0, done=0, busy=0, err=0; after release, in_ready=1.
//  2. From model 0000, push 1010 with tog=0 -> exactly one cycle j=1010,k=0000, then done pulse.
//     Flop bank reads 1010.
//  3. Then push 0110 with tog=1 -> one cycle j=k=1100; done; flops read 0110.
//  4. Push 6 entries back-to-back (0001,0011,0111,1111,1110,1100; tog=0); in_ready must deassert when full.
//     Expect exactly 6 done pulses, flop sequence in order, no entry lost or duplicated.
//  5. LOOPBACK_CHECK_EN with q_fb[0] forced 0; push 0001 -> err=1, err_bits=0001.
//     Push 0000 -> err stays 1, err_bits unchanged.
//  6. Queue 3 entries, assert rst during the first APPLY -> j=k=0 the next cycle, FIFO empty, model 0.
//     No done pulses; the next push after reset is excited against 0000.

Source files
------------

// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK excitation sequencer:
//   state_t  - sequencer FSM states (ST_IDLE / ST_APPLY / ST_SETTLE, 2-bit)
//   JK_*     - per-bit {J,K} excitation codes
//   jk_code  - per-bit excitation rule (model bit, target bit, toggle mode)
// ---------------------------------------------------------------------------
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_APPLY  = 2'b01,
        ST_SETTLE = 2'b10
    } state_t;

    // {J,K} codes as seen by one flop
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Excitation for one flop: hold when already at target, otherwise
    // toggle (tog=1) or drive an explicit set/reset toward the target.
    function automatic logic [1:0] jk_code(input logic m, input logic t, input logic tog);
        logic [1:0] code;
        if (t == m) begin
            code = JK_HOLD;
        end else if (tog) begin
            code = JK_TOG;
        end else if (t) begin
            code = JK_SET;
        end else begin
            code = JK_RST;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// ---------------------------------------------------------------------------
// jk_tgt_fifo
// Synchronous FIFO holding {tog, target} entries for the sequencer.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write strobe and data; ignored while full
//   pop           read strobe; ignored while empty
//   rdata         head entry (valid while !empty)
//   full, empty   status, derived from registered pointers
// ---------------------------------------------------------------------------
module jk_tgt_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         wr_en_s;
    logic         rd_en_s;

    assign wr_en_s = push && !full;
    assign rd_en_s = pop && !empty;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/jk_excite_seq.sv
// ---------------------------------------------------------------------------
// jk_excite_seq
// Upstream driver for a bank of WIDTH JK flip-flops. Target vectors arrive
// on a valid/ready stream, are queued, and each one is applied as a single
// cycle of J/K excitation followed by a settle cycle in which the flop bank
// outputs are valid. An internal model tracks the flop state; it shares rst
// with the flop bank so both start at zero.
//
// Configuration macro: LOOPBACK_CHECK_EN
//   defined   : during SETTLE, q_fb is compared with the target; the first
//               mismatch sets sticky err and captures err_bits = q_fb ^ tgt.
//   undefined : err/err_bits tie to 0 and q_fb is ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready target stream handshake (in_ready = FIFO not full)
//   in_data, in_tog   target vector and toggle-mode flag
//   j, k              registered excitation to the flop bank
//   q_fb              flop bank outputs
//   busy              sequencer active or entries queued
//   done              one-cycle pulse per completed entry
//   err, err_bits     sticky loopback mismatch flag and captured difference
// ---------------------------------------------------------------------------
module jk_excite_seq
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_tog,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    state_t             state_r;
    logic [WIDTH-1:0]   j_r;
    logic [WIDTH-1:0]   k_r;
    logic [WIDTH-1:0]   model_r;
    logic [WIDTH-1:0]   tgt_r;
    logic               done_r;
    logic               err_r;
    logic [WIDTH-1:0]   err_bits_r;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic [WIDTH:0]     fifo_wdata_s;
    logic [WIDTH:0]     fifo_rdata_s;
    logic [WIDTH-1:0]   base_s;
    logic [2*WIDTH-1:0] excite_s;

    // Whole-vector excitation: {J vector, K vector}
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] m,
                                                  input logic [WIDTH-1:0] t,
                                                  input logic             tog);
        logic [WIDTH-1:0] jv;
        logic [WIDTH-1:0] kv;
        logic [1:0]       code;
        jv = {WIDTH{1'b0}};
        kv = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            code  = jk_code(m[i], t[i], tog);
            jv[i] = code[1];
            kv[i] = code[0];
        end
        return {jv, kv};
    endfunction

    assign fifo_wdata_s = {in_tog, in_data};
    assign push_s       = in_valid && !fifo_full_s;

    jk_tgt_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (fifo_wdata_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Pop decision and excitation source: in SETTLE the model register has
    // not yet absorbed tgt, so the next entry is excited against tgt directly
    always_comb begin
        pop_s  = 1'b0;
        base_s = model_r;
        if (state_r == ST_IDLE) begin
            pop_s  = !fifo_empty_s;
            base_s = model_r;
        end else if (state_r == ST_SETTLE) begin
            pop_s  = !fifo_empty_s;
            base_s = tgt_r;
        end else begin
            pop_s  = 1'b0;
            base_s = model_r;
        end
        excite_s = excite(base_s, fifo_rdata_s[WIDTH-1:0], fifo_rdata_s[WIDTH]);
    end

    // Sequencer FSM with registered J/K, model, target and done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            j_r     <= {WIDTH{1'b0}};
            k_r     <= {WIDTH{1'b0}};
            model_r <= {WIDTH{1'b0}};
            tgt_r   <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tgt_r   <= fifo_rdata_s[WIDTH-1:0];
                        j_r     <= excite_s[2*WIDTH-1:WIDTH];
                        k_r     <= excite_s[WIDTH-1:0];
                        state_r <= ST_APPLY;
                    end else begin
                        j_r     <= {WIDTH{1'b0}};
                        k_r     <= {WIDTH{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    // flop bank samples the excitation on this edge
                    j_r     <= {WIDTH{1'b0}};
                    k_r     <= {WIDTH{1'b0}};
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    model_r <= tgt_r;
                    done_r  <= 1'b1;
                    if (pop_s) begin
                        tgt_r   <= fifo_rdata_s[WIDTH-1:0];
                        j_r     <= excite_s[2*WIDTH-1:WIDTH];
                        k_r     <= excite_s[WIDTH-1:0];
                        state_r <= ST_APPLY;
                    end else begin
                        j_r     <= {WIDTH{1'b0}};
                        k_r     <= {WIDTH{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    j_r     <= {WIDTH{1'b0}};
                    k_r     <= {WIDTH{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LOOPBACK_CHECK_EN
    // Sticky loopback checker: only the first mismatch is captured
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r      <= 1'b0;
            err_bits_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_SETTLE) && (q_fb != tgt_r) && !err_r) begin
            err_r      <= 1'b1;
            err_bits_r <= q_fb ^ tgt_r;
        end else begin
            err_r      <= err_r;
            err_bits_r <= err_bits_r;
        end
    end
`else
    logic unused_q_fb_s;
    assign unused_q_fb_s = ^q_fb;
    assign err_r         = 1'b0;
    assign err_bits_r    = {WIDTH{1'b0}};
`endif

    assign in_ready = !fifo_full_s;
    assign busy     = (state_r != ST_IDLE) || !fifo_empty_s;
    assign j        = j_r;
    assign k        = k_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_bits = err_bits_r;

endmodule

// File: tb/tb_jk_excite_seq.sv
// ---------------------------------------------------------------------------
// tb_jk_excite_seq
// Drives jk_excite_seq together with a behavioural JK flop bank (q -> q_fb)
// and checks it against a queue-based reference: every accepted entry is
// expected to complete in order, with its excitation computed from the
// previous target, and the flop bank to land on the target.
// ---------------------------------------------------------------------------
module tb_jk_excite_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = 4'b0000;
    logic         in_tog = 1'b0;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q_fb;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] err_bits;

    logic [W-1:0] q;
    logic [W-1:0] force_mask = 4'b0000;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [W:0]   exp_q[$];
    logic [W-1:0] model_ref = 4'b0000;
    logic         err_exp = 1'b0;
    logic [W-1:0] errb_exp = 4'b0000;
    logic         rst_seen = 1'b1;
    logic [W-1:0] jh1 = 4'b0000, kh1 = 4'b0000, jh2 = 4'b0000, kh2 = 4'b0000;
    logic [7:0]   last_apply = 8'h00;
    int           done_cnt = 0;
    int           full_seen = 0;

    always #5 clk = ~clk;

    assign q_fb = q & ~force_mask;

    jk_excite_seq #(.WIDTH(W), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tog   (in_tog),
        .j        (j),
        .k        (k),
        .q_fb     (q_fb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_bits (err_bits)
    );

    // Behavioural JK flop bank sharing clk/rst with the DUT
    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (rst)                q[i] <= 1'b0;
            else if (j[i] && k[i])  q[i] <= ~q[i];
            else if (j[i])          q[i] <= 1'b1;
            else if (k[i])          q[i] <= 1'b0;
            else                    q[i] <= q[i];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {J,K} from the excitation rules, bit by bit
    function automatic logic [7:0] exc(input logic [W-1:0] m, input logic [W-1:0] t, input logic tog);
        logic [W-1:0] jv = 4'b0000;
        logic [W-1:0] kv = 4'b0000;
        for (int i = 0; i < W; i++) begin
            if (t[i] != m[i]) begin
                if (tog)       begin jv[i] = 1'b1; kv[i] = 1'b1; end
                else if (t[i]) jv[i] = 1'b1;
                else           kv[i] = 1'b1;
            end
        end
        return {jv, kv};
    endfunction

    // Record accepted entries (inputs are stable at the edge)
    always @(posedge clk) begin
        rst_seen <= rst;
        if (!rst && in_valid && in_ready) exp_q.push_back({in_tog, in_data});
    end

    // Scoreboard/monitor on the falling edge
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_seen) begin
            exp_q.delete();
            model_ref = 4'b0000;
            err_exp   = 1'b0;
            errb_exp  = 4'b0000;
            jh1 = 4'b0000; kh1 = 4'b0000; jh2 = 4'b0000; kh2 = 4'b0000;
            check_eq("rst_jk",   {j, k}, 8'h00);
            check_eq("rst_done", done, 1'b0);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_err",  {err, err_bits}, 5'b0);
        end else begin
            if (!in_ready) full_seen++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("done_extra", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("flop_q",    q, e[W-1:0]);
                    check_eq("apply_jk",  {jh2, kh2}, exc(model_ref, e[W-1:0], e[W]));
                    check_eq("settle_jk", {jh1, kh1}, 8'h00);
                    last_apply = {jh2, kh2};
`ifdef LOOPBACK_CHECK_EN
                    if (!err_exp && (q_fb != e[W-1:0])) begin
                        err_exp  = 1'b1;
                        errb_exp = q_fb ^ e[W-1:0];
                    end
`endif
                    model_ref = e[W-1:0];
                    done_cnt++;
                end
            end
            check_eq("err",      err, err_exp);
            check_eq("err_bits", err_bits, errb_exp);
            jh2 = jh1; kh2 = kh1; jh1 = j; kh1 = k;
        end
    end

    // Offer one entry; holds it until accepted (called at a falling edge)
    task automatic push(input logic [W-1:0] d, input logic t);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_tog = t;
        for (int c = 0; c < 100 && !acc; c++) begin
            acc = in_ready;
            @(negedge clk);
        end
        if (!acc) check_eq("push_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk); #1;
            ok = !busy && (exp_q.size() == 0) && !done;
        end
        if (!ok) check_eq("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [W-1:0] seq4 [6];
        seq4[0] = 4'b0001; seq4[1] = 4'b0011; seq4[2] = 4'b0111;
        seq4[3] = 4'b1111; seq4[4] = 4'b1110; seq4[5] = 4'b1100;

        // 1: reset
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check_eq("t1_jk",   {j, k}, 8'h00);
        check_eq("t1_done", done, 1'b0);
        check_eq("t1_busy", busy, 1'b0);
        check_eq("t1_err",  err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t1_ready", in_ready, 1'b1);

        // 2: set/reset excitation from 0000
        push(4'b1010, 1'b0);
        wait_idle();
        check_eq("t2_jk", last_apply, 8'b1010_0000);
        check_eq("t2_q",  q, 4'b1010);

        // 3: toggle excitation
        push(4'b0110, 1'b1);
        wait_idle();
        check_eq("t3_jk", last_apply, 8'b1100_1100);
        check_eq("t3_q",  q, 4'b0110);

        // 4: back-to-back sequence
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) push(seq4[i], 1'b0);
        wait_idle();
        check_eq("t4_done_cnt", done_cnt - d0, 6);
        check_eq("t4_q", q, 4'b1100);

        // 5: loopback mismatch on bit 0
        force_mask = 4'b0001;
        push(4'b0001, 1'b0);
        wait_idle();
`ifdef LOOPBACK_CHECK_EN
        check_eq("t5_err",  {err, err_bits}, 5'b1_0001);
`else
        check_eq("t5_err",  {err, err_bits}, 5'b0_0000);
`endif
        push(4'b0000, 1'b0);
        wait_idle();
`ifdef LOOPBACK_CHECK_EN
        check_eq("t5_err_hold", {err, err_bits}, 5'b1_0001);
`else
        check_eq("t5_err_hold", {err, err_bits}, 5'b0_0000);
`endif
        force_mask = 4'b0000;

        // random traffic with gaps, then a burst that must fill the FIFO
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            push(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        full_seen = 0;
        for (int i = 0; i < 12; i++) push(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        wait_idle();
        check_eq("rand_done_cnt", done_cnt - d0, 52);
        check_eq("burst_full", full_seen > 0, 1'b1);

        // 6: reset during the first APPLY
        d0 = done_cnt;
        in_valid = 1'b1; in_tog = 1'b0; in_data = 4'b0011;
        @(negedge clk);
        in_data = 4'b1001;
        @(negedge clk);
        in_data = 4'b0110;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_jk",   {j, k}, 8'h00);
        check_eq("t6_busy", busy, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t6_no_done", done_cnt - d0, 0);
        check_eq("t6_q",       q, 4'b0000);
        check_eq("t6_busy2",   busy, 1'b0);
        push(4'b0101, 1'b0);
        wait_idle();
        check_eq("t6_jk_after", last_apply, 8'b0101_0000);
        check_eq("t6_q_after",  q, 4'b0101);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
